// File: rtl/mp3_song_streamer.sv
// mp3_song_streamer: streams the selected song from the song ROM to a VS1003 over SCI/SDI.
// Build option MP3_SET_VOLUME_EN: send an SCI_VOL frame (DEF_VOLUME) on every (re)start.
module mp3_song_streamer #(
  parameter int          SONG_NUM      = 3,
  parameter int          SONG_WORDS    = 4096,
  parameter int          ADDR_W        = 14,
  parameter int          HW_RST_CYCLES = 1000,
  parameter logic [15:0] DEF_VOLUME    = 16'h2020
) (
  input  logic              MP3_SCLK,
  input  logic              RESET,
  input  logic [31:0]       SongNow,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [15:0]       ROM_DATA,
  input  logic              MP3_DREQ,
  output logic              MP3_RST,
  output logic              MP3_XCS,
  output logic              MP3_XDCS,
  output logic              MP3_SCK,
  output logic              MP3_SI,
  output logic              PLAYING
);

  localparam int SONG_W = (SONG_NUM > 1) ? $clog2(SONG_NUM) : 1;
  localparam int OFF_W  = (SONG_WORDS > 1) ? $clog2(SONG_WORDS) : 1;
  localparam int HW_W   = $clog2(HW_RST_CYCLES + 1);
  localparam int CNT_W  = (HW_W > 7) ? HW_W : 7;

  localparam logic [CNT_W-1:0] HW_LAST  = CNT_W'(HW_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCI_LAST = CNT_W'(64);
  localparam logic [CNT_W-1:0] SDI_LAST = CNT_W'(32);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SONG_WORDS - 1);

  localparam logic [31:0] SCI_MODE_FRAME = 32'h0200_0804;
  localparam logic [31:0] SCI_VOL_FRAME  = {16'h020B, DEF_VOLUME};

  typedef enum logic [3:0] {
    HWRST,
    WAITRDY0,
    SCI_RST,
    WAITRDY1,
    SCI_VOL,
    WAIT_VOL,
    FETCH,
    SDI_WAIT,
    SDI,
    CHECK
  } state_t;

  typedef struct packed {
    logic rst_n;
    logic xcs;
    logic xdcs;
    logic sck;
    logic si;
    logic playing;
  } pins_t;

  localparam pins_t PINS_RESET = '{rst_n: 1'b0, xcs: 1'b1, xdcs: 1'b1,
                                   sck: 1'b0, si: 1'b0, playing: 1'b0};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       sh_q, sh_d;
  logic [15:0]       word_q, word_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  pins_t             pins_q, pins_d;
  logic [SONG_W-1:0] sel_song;

  function automatic logic [ADDR_W-1:0] rom_addr(input logic [SONG_W-1:0] song,
                                                 input logic [OFF_W-1:0]  off);
    return ADDR_W'(32'(song) * 32'(SONG_WORDS) + 32'(off));
  endfunction

  // Count 0 is the chip-select setup cycle; odd counts present a bit, even counts raise SCK.
  function automatic pins_t decode(input state_t s, input logic [CNT_W-1:0] c, input logic msb);
    pins_t p;
    p = '{rst_n: 1'b1, xcs: 1'b1, xdcs: 1'b1, sck: 1'b0, si: 1'b0, playing: 1'b0};
    case (s)
      HWRST: p.rst_n = 1'b0;
      SCI_RST, SCI_VOL: begin
        p.xcs = 1'b0;
        p.sck = (c != '0) && !c[0];
        p.si  = (c != '0) && msb;
      end
      SDI: begin
        p.xdcs    = 1'b0;
        p.sck     = (c != '0) && !c[0];
        p.si      = (c != '0) && msb;
        p.playing = 1'b1;
      end
      FETCH, SDI_WAIT, CHECK: p.playing = 1'b1;
      default: ;
    endcase
    return p;
  endfunction

  assign sel_song = (SongNow < 32'(SONG_NUM)) ? SONG_W'(SongNow) : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    sh_d       = sh_q;
    word_d     = word_q;
    song_d     = song_q;
    off_d      = off_q;
    rom_addr_d = rom_addr_q;

    unique case (state_q)
      HWRST:    if (cnt_q == HW_LAST) state_d = WAITRDY0;
      WAITRDY0: if (MP3_DREQ) state_d = SCI_RST;
      SCI_RST: begin
        if (cnt_q == SCI_LAST) state_d = WAITRDY1;
        else if ((cnt_q != '0) && !cnt_q[0]) sh_d = {sh_q[30:0], 1'b0};
      end
      WAITRDY1: begin
        if (MP3_DREQ) begin
          song_d = sel_song;
          off_d  = '0;
`ifdef MP3_SET_VOLUME_EN
          state_d = SCI_VOL;
`else
          state_d = FETCH;
`endif
        end
      end
      SCI_VOL: begin
        if (cnt_q == SCI_LAST) state_d = WAIT_VOL;
        else if ((cnt_q != '0) && !cnt_q[0]) sh_d = {sh_q[30:0], 1'b0};
      end
      WAIT_VOL: if (MP3_DREQ) state_d = FETCH;
      FETCH: begin
        // ROM answers one cycle after the address, so the word is taken on the second cycle
        if (cnt_q == CNT_W'(1)) begin
          word_d  = ROM_DATA;
          state_d = SDI_WAIT;
        end
      end
      SDI_WAIT: if (MP3_DREQ) state_d = SDI;
      SDI: begin
        if (cnt_q == SDI_LAST) begin
          state_d = CHECK;
          off_d   = (off_q == OFF_LAST) ? '0 : off_q + OFF_W'(1);
        end else if ((cnt_q != '0) && !cnt_q[0]) begin
          sh_d = {sh_q[30:0], 1'b0};
        end
      end
      CHECK: state_d = (sel_song != song_q) ? SCI_RST : FETCH;
      default: state_d = HWRST;
    endcase

    // Every state entry restarts the counter and loads whatever that state transmits or reads.
    if (state_d != state_q) begin
      cnt_d = '0;
      case (state_d)
        SCI_RST: sh_d = SCI_MODE_FRAME;
        SCI_VOL: sh_d = SCI_VOL_FRAME;
        SDI:     sh_d = {word_q, 16'h0000};
        FETCH:   rom_addr_d = rom_addr(song_d, off_d);
        default: ;
      endcase
    end

    pins_d = decode(state_d, cnt_d, sh_d[31]);
  end

  always_ff @(posedge MP3_SCLK) begin
    if (!RESET) begin
      state_q    <= HWRST;
      cnt_q      <= '0;
      song_q     <= '0;
      off_q      <= '0;
      rom_addr_q <= '0;
      pins_q     <= PINS_RESET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      song_q     <= song_d;
      off_q      <= off_d;
      rom_addr_q <= rom_addr_d;
      pins_q     <= pins_d;
    end
  end

  always_ff @(posedge MP3_SCLK) begin
    sh_q   <= sh_d;
    word_q <= word_d;
  end

  assign ROM_ADDR = rom_addr_q;
  assign MP3_RST  = pins_q.rst_n;
  assign MP3_XCS  = pins_q.xcs;
  assign MP3_XDCS = pins_q.xdcs;
  assign MP3_SCK  = pins_q.sck;
  assign MP3_SI   = pins_q.si;
  assign PLAYING  = pins_q.playing;

endmodule

// File: tb/tb_mp3_song_streamer.sv
// Bench for mp3_song_streamer: decodes the serial bus into frames and checks them against a song/offset model.
module tb_mp3_song_streamer;

  localparam int NSONG  = 3;
  localparam int NWORDS = 8;

  logic        clk = 1'b0;
  logic        RESET;
  logic [31:0] SongNow;
  logic [13:0] ROM_ADDR;
  logic [15:0] ROM_DATA;
  logic        dreq_dir;
  logic        dreq_rnd;
  logic        dreq_rand_en;
  wire         MP3_DREQ = dreq_rand_en ? dreq_rnd : dreq_dir;
  logic        MP3_RST, MP3_XCS, MP3_XDCS, MP3_SCK, MP3_SI, PLAYING;

  mp3_song_streamer #(
    .SONG_NUM(NSONG), .SONG_WORDS(NWORDS), .ADDR_W(14),
    .HW_RST_CYCLES(10), .DEF_VOLUME(16'h1010)
  ) dut (
    .MP3_SCLK(clk), .RESET(RESET), .SongNow(SongNow), .ROM_ADDR(ROM_ADDR),
    .ROM_DATA(ROM_DATA), .MP3_DREQ(MP3_DREQ), .MP3_RST(MP3_RST), .MP3_XCS(MP3_XCS),
    .MP3_XDCS(MP3_XDCS), .MP3_SCK(MP3_SCK), .MP3_SI(MP3_SI), .PLAYING(PLAYING)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_mem [0:31];
  always @(posedge clk) ROM_DATA <= rom_mem[ROM_ADDR[4:0]];

  initial begin
    dreq_rnd = 1'b1;
    forever begin
      @(negedge clk);
      dreq_rnd = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic        sdi;
    int          nbits;
    logic [31:0] value;
    int          low;
    logic [13:0] addr;
    logic        playing;
    logic        edges_ok;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  bit     in_frame = 1'b0;
  logic   prev_sck = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (RESET !== 1'b1) begin
        in_frame = 1'b0;
        prev_sck = 1'b0;
      end else if (MP3_XCS === 1'b0 || MP3_XDCS === 1'b0) begin
        if (!in_frame) begin
          in_frame     = 1'b1;
          cur.sdi      = (MP3_XDCS === 1'b0);
          cur.nbits    = 0;
          cur.value    = '0;
          cur.low      = 0;
          cur.addr     = ROM_ADDR;
          cur.playing  = PLAYING;
          cur.edges_ok = (MP3_SCK === 1'b0);
        end
        cur.low++;
        if (MP3_SCK === 1'b1 && prev_sck === 1'b0) begin
          cur.value = {cur.value[30:0], MP3_SI};
          cur.nbits++;
        end
        prev_sck = MP3_SCK;
      end else begin
        if (in_frame) begin
          cur.edges_ok = cur.edges_ok && (MP3_SCK === 1'b0);
          frames.push_back(cur);
        end
        in_frame = 1'b0;
        prev_sck = MP3_SCK;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned exp_song = 0;
  int unsigned exp_off  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic int unsigned map_song(input logic [31:0] s);
    return (s < NSONG) ? s : 0;
  endfunction

  task automatic pop_frame(output frame_t f);
    int t = 0;
    while (frames.size() == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_timeout", 32'(frames.size() != 0), 32'd1);
    if (frames.size() != 0) f = frames.pop_front();
    else f = '{sdi: 1'b0, nbits: 0, value: '0, low: 0, addr: '0, playing: 1'b0, edges_ok: 1'b0};
  endtask

  task automatic wait_xdcs_low();
    int t = 0;
    while (MP3_XDCS !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("xdcs_start_timeout", 32'(MP3_XDCS === 1'b0), 32'd1);
  endtask

  task automatic expect_sci(input logic [31:0] value);
    frame_t f;
    pop_frame(f);
    chk("sci_kind", 32'(f.sdi), 32'd0);
    chk("sci_value", f.value, value);
    chk("sci_bits", 32'(f.nbits), 32'd32);
    chk("sci_cs_cycles", 32'(f.low), 32'd65);
    chk("sci_playing", 32'(f.playing), 32'd0);
    chk("sci_cs_edges", 32'(f.edges_ok), 32'd1);
  endtask

  task automatic expect_restart(input int unsigned song);
    expect_sci(32'h0200_0804);
`ifdef MP3_SET_VOLUME_EN
    expect_sci(32'h020B_1010);
`endif
    exp_song = song;
    exp_off  = 0;
  endtask

  task automatic expect_sdi();
    frame_t f;
    int unsigned a;
    pop_frame(f);
    a = exp_song * NWORDS + exp_off;
    chk("sdi_kind", 32'(f.sdi), 32'd1);
    chk("sdi_addr", 32'(f.addr), a);
    chk("sdi_data", 32'(f.value), 32'(rom_mem[a[4:0]]));
    chk("sdi_bits", 32'(f.nbits), 32'd16);
    chk("sdi_cs_cycles", 32'(f.low), 32'd33);
    chk("sdi_playing", 32'(f.playing), 32'd1);
    chk("sdi_cs_edges", 32'(f.edges_ok), 32'd1);
    exp_off = (exp_off + 1) % NWORDS;
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_rst"},     32'(MP3_RST),  32'd0);
    chk({tag, "_xcs"},     32'(MP3_XCS),  32'd1);
    chk({tag, "_xdcs"},    32'(MP3_XDCS), 32'd1);
    chk({tag, "_sck"},     32'(MP3_SCK),  32'd0);
    chk({tag, "_si"},      32'(MP3_SI),   32'd0);
    chk({tag, "_addr"},    32'(ROM_ADDR), 32'd0);
    chk({tag, "_playing"}, 32'(PLAYING),  32'd0);
  endtask

  task automatic release_and_check_hwrst(input string tag);
    int n = 0;
    int t = 0;
    RESET = 1'b1;
    while (MP3_RST === 1'b0 && t < 100) begin
      n++;
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(n), 32'd10);
  endtask

  task automatic word_with_change(input logic [31:0] new_song);
    wait_xdcs_low();
    repeat ($urandom_range(1, 20)) @(negedge clk);
    SongNow = new_song;
    expect_sdi();
    if (map_song(new_song) != exp_song) expect_restart(map_song(new_song));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int viol;
    RESET        = 1'b0;
    SongNow      = 32'd1;
    dreq_dir     = 1'b1;
    dreq_rand_en = 1'b0;
    for (int i = 0; i < 32; i++) rom_mem[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_pins("reset");
    release_and_check_hwrst("hwrst_len");

    // Song 1 from its first word, wrapping back to the start of the song
    expect_restart(1);
    for (int i = 0; i < 9; i++) expect_sdi();

    // Reset in the middle of a data word
    wait_xdcs_low();
    repeat ($urandom_range(1, 25)) @(negedge clk);
    RESET = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_pins("midrst");
    frames.delete();
    SongNow = 32'd0;
    repeat (2) @(negedge clk);
    release_and_check_hwrst("hwrst_len2");
    expect_restart(0);
    for (int i = 0; i < 3; i++) expect_sdi();

    // Change to song 2 while word 3 is on the wire
    word_with_change(32'd2);
    expect_sdi();
    expect_sdi();

    // A change that reverts before the word ends must not restart
    wait_xdcs_low();
    repeat ($urandom_range(1, 10)) @(negedge clk);
    SongNow = 32'd1;
    repeat (3) @(negedge clk);
    SongNow = 32'd2;
    expect_sdi();
    expect_sdi();

    // Out-of-range index selects song 0
    word_with_change(32'd5);
    expect_sdi();

    // DREQ low mid-word, then held low before the next word
    wait_xdcs_low();
    repeat ($urandom_range(1, 20)) @(negedge clk);
    dreq_dir = 1'b0;
    expect_sdi();
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (MP3_XDCS !== 1'b1 || MP3_SCK !== 1'b0) viol++;
    end
    chk("stall_idle", 32'(viol), 32'd0);
    dreq_dir = 1'b1;
    n = 0;
    while (MP3_XDCS !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("dreq_latency_ok", 32'(n <= 2), 32'd1);
    expect_sdi();

    // Random DREQ and random song selections
    dreq_rand_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) word_with_change(32'($urandom_range(0, 6)));
      else word_with_change(SongNow);
    end
    dreq_rand_en = 1'b0;
    expect_sdi();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mp3_song_streamer.md
Name: mp3_song_streamer

Overview:
- Consumer side of the song-select interface. Watches `SongNow` from the song-change logic and streams the selected song's data from the song ROM to the VS1003 MP3 decoder over its serial SCI/SDI bus.
- On every song change it aborts the current stream at a word boundary, soft-resets the decoder and restarts from word 0 of the new song.
- Sits between the song-change block, the song ROM and the decoder pins.

Parameters:
- SONG_NUM, 3, number of songs in ROM; `SongNow` values >= SONG_NUM are treated as 0.
- SONG_WORDS, 4096, 16-bit words per song; song n occupies ROM words n*SONG_WORDS .. n*SONG_WORDS+SONG_WORDS-1.
- ADDR_W, 14, ROM address width.
- HW_RST_CYCLES, 1000, cycles `MP3_RST` is held low after reset.
- DEF_VOLUME, 16'h2020, SCI_VOL value written when the optional feature is enabled.

Ports:
- MP3_SCLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous reset, active-low.
- SongNow  in  32  currently selected song index.
- ROM_ADDR  out  ADDR_W  song ROM word address.
- ROM_DATA  in  16  ROM read data, valid 1 cycle after ROM_ADDR.
- MP3_DREQ  in  1  decoder ready-for-data.
- MP3_RST  out  1  decoder hardware reset, active-low.
- MP3_XCS  out  1  SCI chip select, active-low.
- MP3_XDCS  out  1  SDI chip select, active-low.
- MP3_SCK  out  1  serial clock.
- MP3_SI  out  1  serial data, MSB first.
- PLAYING  out  1  high while in the SDI streaming states.

Behaviour:
- Reset (RESET==0 at a clock edge):
  - Outputs: MP3_RST=0, MP3_XCS=1, MP3_XDCS=1, MP3_SCK=0, MP3_SI=0, ROM_ADDR=0, PLAYING=0.
  - Internal state: song register = 0, offset = 0, state = HWRST, counter = 0.
- Serial bit timing: 2 cycles per bit.
  - Phase 0: SCK=0, SI=bit.
  - Phase 1: SCK=1 (decoder samples on the rising edge).
  - Chip select asserts 1 cycle before the first phase 0 and deasserts 1 cycle after the last phase 1, with SCK=0.
- States:
  - HWRST: MP3_RST=0 for HW_RST_CYCLES cycles, then MP3_RST=1 -> WAITRDY0.
  - WAITRDY0: wait MP3_DREQ=1 -> SCI_RST.
  - SCI_RST: 32-bit SCI frame 0x02_00_0804 (write MODE, SM_SDINEW|SM_RESET) with XCS low -> WAITRDY1.
  - WAITRDY1: wait DREQ=1. Latch song register = (SongNow<SONG_NUM)?SongNow:0 and offset = 0 -> FETCH.
  - FETCH: drive ROM_ADDR = song*SONG_WORDS+offset; wait 1 cycle; latch ROM_DATA -> SDI_WAIT.
  - SDI_WAIT: wait DREQ=1 -> SDI.
  - SDI: send the 16-bit word with XDCS low (32 cycles of bit phases). Then:
    - offset==SONG_WORDS-1: offset wraps to 0 (song loops).
    - otherwise: offset+1.
    - -> CHECK.
  - CHECK: if the selected song differs from the song register -> SCI_RST; else -> FETCH.
- PLAYING=1 in FETCH, SDI_WAIT, SDI and CHECK.
- Song-change rules:
  - A change is only acted on in CHECK; a word already in flight always completes.
  - A change that reverts before CHECK causes no restart.
  - A change during HWRST/SCI_RST/WAITRDY* is picked up at the WAITRDY1 latch.
- DREQ low mid-word does not stall the word; it is only checked before each word.
- Reset mid-transfer: outputs go to reset values on the same edge; the partial frame is dropped.
- Address arithmetic is unsigned, truncated to ADDR_W.

Optional Feature:
- Macro: MP3_SET_VOLUME_EN.
- Defined: after WAITRDY1 an extra SCI_VOL state sends SCI frame 0x02_0B_DEF_VOLUME, waits for DREQ=1, then -> FETCH. This happens on every (re)start.
- Undefined: WAITRDY1 goes directly to FETCH and no volume frame is ever sent.

Test Plan:
- Reset, HW_RST_CYCLES=10, DREQ tied 1 -> MP3_RST low for 10 cycles; first XCS frame shifts 0x02000804 MSB-first, 64 SCK phases.
- SongNow=1, SONG_WORDS=8, ROM word = address -> ROM_ADDR 8,9,…,15,8; SDI words 0x0008..0x000F then 0x0008 (loop).
- SongNow 0->2 during the SDI of word 3 -> word 3 completes; next frame is SCI 0x02000804; next data word from ROM_ADDR 2*SONG_WORDS.
- SongNow=5 with SONG_NUM=3 -> streams song 0 (ROM_ADDR starts at 0).
- DREQ held 0 for 50 cycles in SDI_WAIT -> XDCS stays 1 and SCK stays 0; the word starts within 2 cycles of DREQ rising.
- With MP3_SET_VOLUME_EN, DEF_VOLUME=16'h1010 -> frame 0x020B1010 follows the reset frame before any SDI; without the macro, none.
